// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM types, command encodings and bus widths
// Contents: arbiter state enum, {cs_n, ras_n, cas_n, we_n} command codes,
// command/bank/address widths and grant bit positions.
package sdram_pkg;

  localparam int CMD_W  = 4;
  localparam int BA_W   = 2;
  localparam int ADDR_W = 13;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [CMD_W-1:0] CMD_NOP       = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_AREF      = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_WRITE     = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_READ      = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_MRS       = 4'b0000;

  // Bit positions inside the picker's one-hot grant vector
  localparam int GNT_AREF = 2;
  localparam int GNT_WR   = 1;
  localparam int GNT_RD   = 0;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARB   = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } state_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// rtl/sdram_arbit_if.sv - generator-side requests/buses and pin-side outputs of the arbiter
// Modports: slave = arbiter (takes requests and generator buses, drives grants and pins);
//           master = generators/environment (drives requests and buses, observes grants and pins).
interface sdram_arbit_if;
  import sdram_pkg::*;

  logic              init_end;
  logic [CMD_W-1:0]  init_cmd;
  logic [BA_W-1:0]   init_ba;
  logic [ADDR_W-1:0] init_addr;

  logic              aref_req;
  logic              aref_end;
  logic [CMD_W-1:0]  aref_cmd;
  logic [BA_W-1:0]   aref_ba;
  logic [ADDR_W-1:0] aref_addr;

  logic              wr_req;
  logic              wr_end;
  logic [CMD_W-1:0]  wr_cmd;
  logic [BA_W-1:0]   wr_ba;
  logic [ADDR_W-1:0] wr_addr;

  logic              rd_req;
  logic              rd_end;
  logic [CMD_W-1:0]  rd_cmd;
  logic [BA_W-1:0]   rd_ba;
  logic [ADDR_W-1:0] rd_addr;

  logic              aref_en;
  logic              wr_en;
  logic              rd_en;
  logic [CMD_W-1:0]  sdram_cmd;
  logic [BA_W-1:0]   sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;

  modport slave (
    input  init_end, init_cmd, init_ba, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    output aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr
  );

  modport master (
    output init_end, init_cmd, init_ba, init_addr,
    output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_ba, wr_addr,
    output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
    input  aref_en, wr_en, rd_en, sdram_cmd, sdram_ba, sdram_addr
  );

endinterface

// File: rtl/sdram_arbit_pick.sv
// rtl/sdram_arbit_pick.sv - combinational request picker, refresh first, then write/read
// Ports: aref_req/wr_req/rd_req request levels; last_wr = previous data grant was a write;
//        grant one-hot (GNT_AREF/GNT_WR/GNT_RD) or all zero when nothing is requested.
module sdram_arbit_pick
  import sdram_pkg::*;
(
  input  logic       aref_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       last_wr,
  output logic [2:0] grant
);

  // When both write and read request, last_wr hands the turn to read.
  // A caller that holds last_wr at 0 gets plain write-over-read priority.
  logic rd_turn;
  assign rd_turn = rd_req & (~wr_req | last_wr);

  always_comb begin
    grant = 3'b000;
    if (aref_req) begin
      grant[GNT_AREF] = 1'b1;
    end else if (rd_turn) begin
      grant[GNT_RD] = 1'b1;
    end else if (wr_req) begin
      grant[GNT_WR] = 1'b1;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command-bus arbiter for init, auto-refresh, write and read generators
// Ports: clk; rst synchronous active-high; bus (sdram_arbit_if.slave) carrying generator
//        requests/end pulses/command buses in and registered grants plus muxed pin bus out.
// Build option: SDRAM_ARBIT_RR_EN makes write and read alternate when both request.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [CMD_W-1:0]  NOP_CMD   = 4'b0111,
  parameter logic [BA_W-1:0]   IDLE_BA   = 2'b11,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 13'h1FFF
) (
  input  logic          clk,
  input  logic          rst,
  sdram_arbit_if.slave  bus
);

  state_t     state;
  logic       aref_en_q;
  logic       wr_en_q;
  logic       rd_en_q;
  logic       last_wr;
  logic [2:0] pick;

`ifdef SDRAM_ARBIT_RR_EN
  logic last_wr_q;
  assign last_wr = last_wr_q;
`else
  assign last_wr = 1'b0;
`endif

  sdram_arbit_pick u_pick (
    .aref_req (bus.aref_req),
    .wr_req   (bus.wr_req),
    .rd_req   (bus.rd_req),
    .last_wr  (last_wr),
    .grant    (pick)
  );

  // Grants are only ever set from ARB and cleared on the way back to ARB,
  // which guarantees at least one NOP cycle between consecutive grants.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
`ifdef SDRAM_ARBIT_RR_EN
      last_wr_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_INIT: begin
          if (bus.init_end) state <= ST_ARB;
        end
        ST_ARB: begin
          if (pick[GNT_AREF]) begin
            state     <= ST_AREF;
            aref_en_q <= 1'b1;
          end else if (pick[GNT_WR]) begin
            state   <= ST_WRITE;
            wr_en_q <= 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
            last_wr_q <= 1'b1;
`endif
          end else if (pick[GNT_RD]) begin
            state   <= ST_READ;
            rd_en_q <= 1'b1;
`ifdef SDRAM_ARBIT_RR_EN
            last_wr_q <= 1'b0;
`endif
          end
        end
        ST_AREF: begin
          if (bus.aref_end) begin
            state     <= ST_ARB;
            aref_en_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (bus.wr_end) begin
            state   <= ST_ARB;
            wr_en_q <= 1'b0;
          end
        end
        ST_READ: begin
          if (bus.rd_end) begin
            state   <= ST_ARB;
            rd_en_q <= 1'b0;
          end
        end
        default: begin
          // Unreachable encodings fall back to an idle bus with no owner.
          state     <= ST_ARB;
          aref_en_q <= 1'b0;
          wr_en_q   <= 1'b0;
          rd_en_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.aref_en = aref_en_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.rd_en   = rd_en_q;

  // Pin mux follows the registered state directly so generator commands reach
  // the pins in the same cycle they are presented.
  always_comb begin
    bus.sdram_cmd  = NOP_CMD;
    bus.sdram_ba   = IDLE_BA;
    bus.sdram_addr = IDLE_ADDR;
    case (state)
      ST_INIT: begin
        bus.sdram_cmd  = bus.init_cmd;
        bus.sdram_ba   = bus.init_ba;
        bus.sdram_addr = bus.init_addr;
      end
      ST_AREF: begin
        bus.sdram_cmd  = bus.aref_cmd;
        bus.sdram_ba   = bus.aref_ba;
        bus.sdram_addr = bus.aref_addr;
      end
      ST_WRITE: begin
        bus.sdram_cmd  = bus.wr_cmd;
        bus.sdram_ba   = bus.wr_ba;
        bus.sdram_addr = bus.wr_addr;
      end
      ST_READ: begin
        bus.sdram_cmd  = bus.rd_cmd;
        bus.sdram_ba   = bus.rd_ba;
        bus.sdram_addr = bus.rd_addr;
      end
      default: begin
        bus.sdram_cmd  = NOP_CMD;
        bus.sdram_ba   = IDLE_BA;
        bus.sdram_addr = IDLE_ADDR;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - directed plus randomized self-checking bench for sdram_arbit
module tb_sdram_arbit;

  logic clk;
  logic rst;

  sdram_arbit_if bus_if ();

  sdram_arbit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference: who owns the bus (0 none, 1 refresh, 2 write, 3 read),
  // whether power-up is still pending, and whose turn it is between data requests.
  bit in_init = 1'b1;
  int owner   = 0;
  bit m_last_wr = 1'b0;

`ifdef SDRAM_ARBIT_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the reference by one clock edge using the inputs present at that edge.
  task automatic model_step();
    if (rst) begin
      in_init   = 1'b1;
      owner     = 0;
      m_last_wr = 1'b0;
    end else if (in_init) begin
      if (bus_if.init_end) in_init = 1'b0;
    end else if (owner == 0) begin
      if (bus_if.aref_req) owner = 1;
      else if (bus_if.wr_req && bus_if.rd_req) owner = (RR && m_last_wr) ? 3 : 2;
      else if (bus_if.wr_req) owner = 2;
      else if (bus_if.rd_req) owner = 3;
      if (owner == 2) m_last_wr = 1'b1;
      if (owner == 3) m_last_wr = 1'b0;
    end else begin
      if ((owner == 1 && bus_if.aref_end) || (owner == 2 && bus_if.wr_end) ||
          (owner == 3 && bus_if.rd_end))
        owner = 0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [18:0] exp_bus;
    if (in_init)         exp_bus = {bus_if.init_cmd, bus_if.init_ba, bus_if.init_addr};
    else if (owner == 1) exp_bus = {bus_if.aref_cmd, bus_if.aref_ba, bus_if.aref_addr};
    else if (owner == 2) exp_bus = {bus_if.wr_cmd, bus_if.wr_ba, bus_if.wr_addr};
    else if (owner == 3) exp_bus = {bus_if.rd_cmd, bus_if.rd_ba, bus_if.rd_addr};
    else                 exp_bus = {4'b0111, 2'b11, 13'h1FFF};
    chk({tag, "_grants"}, {29'd0, bus_if.aref_en, bus_if.wr_en, bus_if.rd_en},
        {29'd0, owner == 1, owner == 2, owner == 3});
    chk({tag, "_bus"}, {13'd0, bus_if.sdram_cmd, bus_if.sdram_ba, bus_if.sdram_addr},
        {13'd0, exp_bus});
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rand_buses();
    bus_if.init_cmd  = 4'($urandom);  bus_if.init_ba = 2'($urandom); bus_if.init_addr = 13'($urandom);
    bus_if.aref_cmd  = 4'($urandom);  bus_if.aref_ba = 2'($urandom); bus_if.aref_addr = 13'($urandom);
    bus_if.wr_cmd    = 4'($urandom);  bus_if.wr_ba   = 2'($urandom); bus_if.wr_addr   = 13'($urandom);
    bus_if.rd_cmd    = 4'($urandom);  bus_if.rd_ba   = 2'($urandom); bus_if.rd_addr   = 13'($urandom);
  endtask

  int seq_got [4];
  int seq_exp [4];

  initial begin
    rst = 1'b1;
    bus_if.init_end = 1'b0;
    bus_if.aref_req = 1'b0; bus_if.aref_end = 1'b0;
    bus_if.wr_req   = 1'b0; bus_if.wr_end   = 1'b0;
    bus_if.rd_req   = 1'b0; bus_if.rd_end   = 1'b0;
    rand_buses();

    // Reset, then 20 cycles of INIT with requests that must be ignored
    tick("reset0");
    tick("reset1");
    chk("reset_grants_zero", {29'd0, bus_if.aref_en, bus_if.wr_en, bus_if.rd_en}, 32'd0);
    rst = 1'b0;
    bus_if.wr_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_buses();
      tick("init_wait");
    end
    bus_if.wr_req = 1'b0;
    bus_if.init_end = 1'b1;
    tick("init_done");
    chk("idle_nop", {13'd0, bus_if.sdram_cmd, bus_if.sdram_ba, bus_if.sdram_addr},
        {13'd0, 4'b0111, 2'b11, 13'h1FFF});
    bus_if.init_end = 1'b0;
    tick("init_end_drop_ignored");

    // All three request: refresh, then write, then read once write drops
    bus_if.aref_req = 1'b1; bus_if.wr_req = 1'b1; bus_if.rd_req = 1'b1;
    tick("all_req");
    chk("aref_first", {31'd0, bus_if.aref_en}, 32'd1);
    tick("aref_hold");
    bus_if.aref_end = 1'b1; bus_if.aref_req = 1'b0;
    tick("aref_end");
    bus_if.aref_end = 1'b0;
    chk("gap_after_aref", {29'd0, bus_if.aref_en, bus_if.wr_en, bus_if.rd_en}, 32'd0);
    bus_if.wr_cmd = 4'b0100; bus_if.wr_addr = 13'h0A5;
    tick("wr_grant");
    chk("wr_after_aref", {31'd0, bus_if.wr_en}, 32'd1);
    chk("wr_cmd_mirror", {28'd0, bus_if.sdram_cmd}, 32'h4);
    chk("wr_addr_mirror", {19'd0, bus_if.sdram_addr}, 32'h0A5);
    bus_if.wr_req = 1'b0;
    tick("wr_req_dropped");
    chk("wr_held", {31'd0, bus_if.wr_en}, 32'd1);
    bus_if.rd_end = 1'b1;
    tick("stray_rd_end");
    bus_if.rd_end = 1'b0;
    chk("stray_rd_end_ignored", {31'd0, bus_if.wr_en}, 32'd1);
    bus_if.wr_end = 1'b1;
    tick("wr_end");
    bus_if.wr_end = 1'b0;
    tick("rd_grant");
    chk("rd_after_wr", {31'd0, bus_if.rd_en}, 32'd1);
    tick("rd_hold");

    // Reset in the middle of a read grant
    rst = 1'b1;
    rand_buses();
    tick("rst_mid_read");
    chk("rd_en_cleared", {31'd0, bus_if.rd_en}, 32'd0);
    rst = 1'b0;
    bus_if.rd_req = 1'b0;
    bus_if.init_end = 1'b1;
    tick("reinit");
    bus_if.init_end = 1'b0;

    // Write and read held high, end pulse 8 cycles after each grant
    bus_if.wr_req = 1'b1; bus_if.rd_req = 1'b1;
    seq_exp = RR ? '{2, 3, 2, 3} : '{2, 2, 2, 2};
    for (int g = 0; g < 4; g++) begin
      int waited;
      waited = 0;
      while (!(bus_if.wr_en || bus_if.rd_en) && waited < 5) begin
        tick("seq_wait");
        waited++;
      end
      seq_got[g] = bus_if.wr_en ? 2 : (bus_if.rd_en ? 3 : 0);
      chk($sformatf("seq_grant%0d", g), seq_got[g], seq_exp[g]);
      for (int k = 0; k < 7; k++) tick("seq_hold");
      bus_if.wr_end = bus_if.wr_en;
      bus_if.rd_end = bus_if.rd_en;
      tick("seq_end");
      bus_if.wr_end = 1'b0; bus_if.rd_end = 1'b0;
    end

    // Randomized traffic against the reference
    for (int i = 0; i < 3000; i++) begin
      rand_buses();
      rst             = ($urandom_range(0, 199) == 0);
      bus_if.init_end = ($urandom_range(0, 3) == 0);
      bus_if.aref_req = ($urandom_range(0, 9) == 0);
      bus_if.wr_req   = ($urandom_range(0, 2) != 0);
      bus_if.rd_req   = ($urandom_range(0, 2) != 0);
      bus_if.aref_end = ($urandom_range(0, 3) == 0);
      bus_if.wr_end   = ($urandom_range(0, 4) == 0);
      bus_if.rd_end   = ($urandom_range(0, 4) == 0);
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
